// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read pacer: FSM state encoding,
// the post-handshake settle interval and default widths.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 4;
  localparam int DEFAULT_DELAY_WIDTH = 4;
  localparam int SETTLE_CYCLES       = 2;
  localparam int RD_COUNT_WIDTH      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } pacer_state_t;

endpackage

// File: rtl/pacer_delay_cnt.sv
// Loadable down-counter for the inter-read delay. Terminal count is flagged
// when the counter holds 1, so a load of N yields exactly N counting cycles.
module pacer_delay_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == WIDTH'(1));

endmodule

// File: rtl/fifo_read_pacer.sv
// Paces single-word reads from an upstream FIFO and holds each word for a
// downstream consumer. Optional read counter: define PACER_RD_COUNT_EN.
module fifo_read_pacer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DELAY_WIDTH = DEFAULT_DELAY_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DELAY_WIDTH-1:0] delay_cfg,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_read_en,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
`ifdef PACER_RD_COUNT_EN
  ,
  output logic [RD_COUNT_WIDTH-1:0] rd_count
`endif
);

  // Downstream handshake: a word transfers on a rising edge where out_valid
  // and out_ready are both high; out_ready while out_valid is low is ignored.

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  pacer_state_t        state;
  pacer_state_t        state_next;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_tc;
  logic                settle_load;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                idle_qualified;

  pacer_delay_cnt #(
    .WIDTH(DELAY_WIDTH)
  ) u_delay_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(delay_cfg),
    .dec       (cnt_dec),
    .tc        (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The settle interval spans both IDLE cycles after a handshake: the first
  // ignores fifo_empty, the second samples it and may already launch.
  assign idle_qualified = (settle_cnt == '0);

  always_comb begin
    state_next  = state;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    settle_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (idle_qualified && !fifo_empty) begin
          if (delay_cfg == '0) begin
            state_next = ST_READ;
          end else begin
            cnt_load   = 1'b1;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_tc) begin
          state_next = ST_READ;
        end
      end
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          settle_load = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (settle_load) begin
      settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
    end else if ((state == ST_IDLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      out_data  <= fifo_data;
      out_valid <= 1'b1;
    end else if ((state == ST_HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign fifo_read_en = (state == ST_READ);
  assign busy         = (state != ST_IDLE);

`ifdef PACER_RD_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
    end else if (state == ST_READ) begin
      rd_count <= rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_pacer.sv
// Directed bench for fifo_read_pacer: pacing, hold, settle, reset abort and,
// with PACER_RD_COUNT_EN defined, the wrapping read counter.
module tb_fifo_read_pacer;

  logic       clk;
  logic       rst;
  logic [3:0] delay_cfg;
  logic       fifo_empty;
  logic [3:0] fifo_data;
  logic       fifo_read_en;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef PACER_RD_COUNT_EN
  logic [7:0] rd_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_read_pacer #(
    .DATA_WIDTH (4),
    .DELAY_WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .delay_cfg   (delay_cfg),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_en(fifo_read_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
`ifdef PACER_RD_COUNT_EN
    ,
    .rd_count    (rd_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    fifo_empty = 1'b1;
    out_ready  = 1'b0;
    delay_cfg  = 4'd0;
    fifo_data  = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Ticks until fifo_read_en is seen or max ticks elapse; n = ticks taken.
  task automatic wait_pulse(input int max, output int n);
    n = 0;
    while (fifo_read_en !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_read_en got %b want 0", fifo_read_en); end
`ifdef PACER_RD_COUNT_EN
    n_checks++;
    if (rd_count !== 8'd0) begin n_fail++; $display("FAIL reset_rd_count got %0d want 0", rd_count); end
`endif
  endtask

  task automatic test_zero_delay();
    int n;
    apply_reset();
    delay_cfg  = 4'd0;
    fifo_data  = 4'hA;
    out_ready  = 1'b1;
    fifo_empty = 1'b0;
    wait_pulse(20, n);
    n_checks++;
    if (n != 1) begin n_fail++; $display("FAIL zd_first_pulse got %0d want 1", n); end
    tick();
    n_checks += 2;
    if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL zd_pulse_width got %b want 0", fifo_read_en); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zd_valid_early got %b want 0", out_valid); end
    tick();
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zd_valid got %b want 1", out_valid); end
    if (out_data !== 4'hA) begin n_fail++; $display("FAIL zd_data got %h want a", out_data); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL zd_busy got %b want 1", busy); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zd_valid_clear got %b want 0", out_valid); end
    wait_pulse(20, n);
    n_checks++;
    if (n != 2) begin n_fail++; $display("FAIL zd_spacing got %0d want 2 (spacing 5)", n); end
  endtask

  task automatic test_delay();
    int n;
    apply_reset();
    delay_cfg  = 4'd3;
    out_ready  = 1'b1;
    fifo_data  = 4'h6;
    fifo_empty = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL dl_wait_busy got %b want 1", busy); end
    delay_cfg = 4'd9;
    wait_pulse(40, n);
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL dl_first_pulse got %0d want 3", n); end
    delay_cfg = 4'd3;
    for (int k = 0; k < 2; k++) begin
      tick();
      wait_pulse(40, n);
      n_checks++;
      if (n != 7) begin n_fail++; $display("FAIL dl_spacing%0d got %0d want 7 (spacing 8)", k, n); end
    end
  endtask

  task automatic test_max_delay();
    int n;
    apply_reset();
    delay_cfg  = 4'hF;
    out_ready  = 1'b1;
    fifo_empty = 1'b0;
    wait_pulse(40, n);
    n_checks++;
    if (n != 16) begin n_fail++; $display("FAIL max_delay_pulse got %0d want 16", n); end
  endtask

  task automatic test_hold();
    int n;
    apply_reset();
    delay_cfg  = 4'd0;
    fifo_data  = 4'h5;
    out_ready  = 1'b0;
    fifo_empty = 1'b0;
    wait_pulse(20, n);
    n_checks++;
    if (n != 1) begin n_fail++; $display("FAIL hold_pulse got %0d want 1", n); end
    tick();
    tick();
    fifo_data = 4'hF;
    for (int k = 0; k < 10; k++) begin
      n_checks += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid c%0d got %b want 1", k, out_valid); end
      if (out_data !== 4'h5) begin n_fail++; $display("FAIL hold_data c%0d got %h want 5", k, out_data); end
      if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL hold_read_en c%0d got %b want 0", k, fifo_read_en); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_release_busy got %b want 0", busy); end
  endtask

  task automatic test_empty();
    apply_reset();
    delay_cfg  = 4'd0;
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks += 2;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy c%0d got %b want 0", k, busy); end
      if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL empty_read_en c%0d got %b want 0", k, fifo_read_en); end
    end
  endtask

  task automatic test_settle();
    int n;
    apply_reset();
    delay_cfg  = 4'd0;
    fifo_data  = 4'h3;
    out_ready  = 1'b1;
    fifo_empty = 1'b0;
    wait_pulse(20, n);
    tick();
    tick();
    tick();
    tick();
    n_checks += 2;
    if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL settle_early_read got %b want 0", fifo_read_en); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL settle_busy got %b want 0", busy); end
    fifo_empty = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL settle_read c%0d got %b want 0", k, fifo_read_en); end
    end
  endtask

  task automatic test_reset_capture();
    int n;
    apply_reset();
    delay_cfg  = 4'd0;
    fifo_data  = 4'h7;
    out_ready  = 1'b1;
    fifo_empty = 1'b0;
    wait_pulse(20, n);
    tick();
    rst = 1'b1;
    tick();
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rc_valid got %b want 0", out_valid); end
    if (out_data !== 4'h0) begin n_fail++; $display("FAIL rc_data got %h want 0", out_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rc_busy got %b want 0", busy); end
    if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL rc_read_en got %b want 0", fifo_read_en); end
`ifdef PACER_RD_COUNT_EN
    n_checks++;
    if (rd_count !== 8'd0) begin n_fail++; $display("FAIL rc_rd_count got %0d want 0", rd_count); end
`endif
    fifo_empty = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rc_discard c%0d got %b want 0", k, out_valid); end
    end
  endtask

`ifdef PACER_RD_COUNT_EN
  task automatic test_rd_count();
    int n;
    int pulses;
    apply_reset();
    delay_cfg  = 4'd0;
    out_ready  = 1'b1;
    fifo_empty = 1'b0;
    pulses = 0;
    for (int k = 0; k < 257; k++) begin
      wait_pulse(20, n);
      if (fifo_read_en === 1'b1) pulses++;
      tick();
    end
    n_checks += 2;
    if (pulses != 257) begin n_fail++; $display("FAIL rdc_pulses got %0d want 257", pulses); end
    if (rd_count !== 8'd1) begin n_fail++; $display("FAIL rdc_wrap got %0d want 1", rd_count); end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    delay_cfg  = 4'd0;
    fifo_empty = 1'b1;
    fifo_data  = 4'd0;
    out_ready  = 1'b0;
    test_reset();
    test_zero_delay();
    test_delay();
    test_max_delay();
    test_hold();
    test_empty();
    test_settle();
    test_reset_capture();
`ifdef PACER_RD_COUNT_EN
    test_rd_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_pacer.md
FIFO_READ_PACER -- requirements
Module: fifo_read_pacer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, width of FIFO word and output word.
REQ-002 SHALL have parameter DELAY_WIDTH, default 4, width of programmable inter-read delay.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port delay_cfg  input  DELAY_WIDTH  number of idle cycles inserted before each FIFO read.
REQ-006 SHALL have port fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-007 SHALL have port fifo_data  input  DATA_WIDTH  FIFO read data, valid one cycle after fifo_read_en.
REQ-008 SHALL have port fifo_read_en  output  1  one-cycle read strobe to the FIFO.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  captured word presented downstream.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, READ, CAPTURE, HOLD, with state held in a register.
REQ-014 IDLE, qualified (see REQ-020), fifo_empty=0: delay_cfg=0 -> READ; delay_cfg>0 -> load delay counter with delay_cfg, go to WAIT.
REQ-015 WAIT SHALL decrement the counter once per cycle; at counter==1 -> READ, giving exactly delay_cfg cycles in WAIT.
REQ-016 delay_cfg SHALL be sampled only on the IDLE->WAIT transition; changes during WAIT are ignored.
REQ-017 READ SHALL last exactly one cycle with fifo_read_en=1, then -> CAPTURE; fifo_read_en SHALL be 0 in every other state.
REQ-018 CAPTURE SHALL register fifo_data into out_data and set out_valid=1 at the closing edge, then -> HOLD.
REQ-019 HOLD: out_data and out_valid stable; when out_ready=1, out_valid clears at that edge and FSM -> IDLE; out_ready=0 holds indefinitely.
REQ-020 IDLE SHALL ignore fifo_empty for the first 2 cycles after entry from HOLD (settle interval for lagging upstream flags); entry from reset is qualified immediately.
REQ-021 Minimum spacing between fifo_read_en pulses SHALL be 5 + delay_cfg cycles (READ, CAPTURE, HOLD>=1, 2 settle cycles in IDLE, delay_cfg WAIT cycles).
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 Delay counter arithmetic SHALL be DELAY_WIDTH unsigned; maximum delay_cfg (all ones) SHALL give 2^DELAY_WIDTH-1 WAIT cycles, no wrap.

Reset
REQ-024 rst=1 at any clock edge SHALL force IDLE, out_valid=0, out_data=0, fifo_read_en=0, busy=0, delay counter=0, settle counter=0.
REQ-025 Reset during READ or CAPTURE SHALL abort the transfer; the FIFO word in flight is discarded and not presented.

Configuration
REQ-026 Macro PACER_RD_COUNT_EN defined: SHALL add output rd_count (8 bits), reset to 0, incremented on each READ cycle, wrapping 255->0.
REQ-027 PACER_RD_COUNT_EN undefined: rd_count port and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the FSM state typedef (pacer_state_t), SETTLE_CYCLES=2 and default DATA_WIDTH/DELAY_WIDTH constants.
REQ-029 The loadable down-counter SHALL be a sub-module pacer_delay_cnt (load, decrement, terminal-count output); all else in the top.

Verification
REQ-030 delay_cfg=0, fifo_empty=0, fifo_data=4'hA, out_ready=1 -> fifo_read_en pulses 1 cycle, out_data=4'hA, out_valid=1 two cycles after the pulse.
REQ-031 delay_cfg=3, fifo_empty=0 from reset release -> exactly 3 WAIT cycles, then fifo_read_en pulse; successive pulses 8 cycles apart with out_ready=1.
REQ-032 out_ready=0 for 10 cycles in HOLD -> out_valid=1 and out_data stable throughout, no fifo_read_en; out_ready=1 -> out_valid=0 next cycle.
REQ-033 fifo_empty=1 throughout -> FSM stays IDLE, busy=0, fifo_read_en never asserted.
REQ-034 rst=1 in CAPTURE cycle -> next cycle out_valid=0, out_data=0, busy=0; rd_count=0 with PACER_RD_COUNT_EN.
REQ-035 PACER_RD_COUNT_EN, 257 reads, out_ready=1 -> rd_count=1.
